// File: rtl/rs_pulse_driver_pkg.sv
// Shared types for the RS pulse driver: per-channel FSM states, default parameter
// values and the set/reset conflict resolver.
package rs_pulse_driver_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    HELD = 3'd3,
    REL  = 3'd4
  } ch_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_CNT_W           = 16;
  localparam int DEFAULT_REPEAT_CYCLES   = 1000;

  typedef struct packed {
    logic s;
    logic r;
    logic conflict;
  } rs_out_t;

  // Simultaneous set and reset requests cancel each other and raise conflict instead.
  function automatic rs_out_t resolve_fire(input logic fire_s, input logic fire_r);
    rs_out_t o;
    o.s        = fire_s & ~fire_r;
    o.r        = fire_r & ~fire_s;
    o.conflict = fire_s & fire_r;
    return o;
  endfunction

  function automatic int max_int(input int a, input int b);
    int m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/rs_pulse_driver_if.sv
// Button inputs and RS-side outputs of the pulse driver, bundled with producer/consumer views.
interface rs_pulse_driver_if;

  logic btn_s;
  logic btn_r;
  logic s;
  logic r;
  logic conflict;
  logic held;

  modport master (
    output btn_s,
    output btn_r,
    input  s,
    input  r,
    input  conflict,
    input  held
  );

  modport slave (
    input  btn_s,
    input  btn_r,
    output s,
    output r,
    output conflict,
    output held
  );

endinterface

// File: rtl/rs_pulse_driver_chk.sv
// Protocol checker for the RS-facing outputs: set and reset never overlap, and at most
// one of s, r, conflict is raised in any cycle.
module rs_pulse_driver_chk (
  input logic clk,
  input logic rst,
  input logic s,
  input logic r,
  input logic conflict
);

  a_no_set_and_reset: assert property (@(posedge clk) disable iff (rst) !(s && r));

  a_outputs_exclusive: assert property (@(posedge clk) disable iff (rst) $onehot0({s, r, conflict}));

endmodule

// File: rtl/rs_pulse_driver_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce/repeat FSM and saturating counter.
// Auto-repeat in HELD is built only when RS_PULSE_DRIVER_AUTOREPEAT_EN is defined.
module rs_debounce_ch
  import rs_pulse_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic fire,
  output logic down
);

  localparam int CNT_NEED = max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || CNT_W < $clog2(CNT_NEED + 1)) begin : g_bad_cfg
    $error("rs_debounce_ch: need DEBOUNCE_CYCLES >= 2 and CNT_W wide enough for max(DEBOUNCE_CYCLES, REPEAT_CYCLES)");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef RS_PULSE_DRIVER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    if (cnt_q == CNT_MAX) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + CNT_ONE;
    end
  end

  // The debounce exit fires on the edge where the incremented count would hit the
  // last stable sample, so a press needs exactly DEBOUNCE_CYCLES high samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (sync2_q) begin
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = FIRE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ARM;
          cnt_d   = cnt_inc;
        end
      end
      FIRE: begin
        state_d = HELD;
        cnt_d   = CNT_ZERO;
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = REL;
          cnt_d   = CNT_ZERO;
`ifdef RS_PULSE_DRIVER_AUTOREPEAT_EN
        end else if (cnt_q == REP_LAST) begin
          state_d = FIRE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = HELD;
          cnt_d   = cnt_inc;
        end
`else
        end else begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end
`endif
      end
      REL: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = REL;
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fire = (state_q == FIRE);
  assign down = (state_q == HELD) || (state_q == REL);

endmodule

// File: rtl/rs_pulse_driver.sv
// Top of the RS pulse driver: two debounce channels, conflict resolver and output registers.
// Optional auto-repeat while held is enabled by defining RS_PULSE_DRIVER_AUTOREPEAT_EN.
module rs_pulse_driver
  import rs_pulse_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  rs_pulse_driver_if.slave bus
);

  logic    fire_s, fire_r;
  logic    down_s, down_r;
  rs_out_t out_q, out_d;
  logic    held_q, held_d;

  rs_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_ch_s (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_s),
    .fire (fire_s),
    .down (down_s)
  );

  rs_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_ch_r (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_r),
    .fire (fire_r),
    .down (down_r)
  );

  always_comb begin
    out_d  = resolve_fire(fire_s, fire_r);
    held_d = down_s | down_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '{s: 1'b0, r: 1'b0, conflict: 1'b0};
      held_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      held_q <= held_d;
    end
  end

  assign bus.s        = out_q.s;
  assign bus.r        = out_q.r;
  assign bus.conflict = out_q.conflict;
  assign bus.held     = held_q;

  rs_pulse_driver_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .s        (out_q.s),
    .r        (out_q.r),
    .conflict (out_q.conflict)
  );

endmodule

// File: tb/tb_rs_pulse_driver.sv
// Directed bench for rs_pulse_driver with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8; expected
// pulse positions follow RS_PULSE_DRIVER_AUTOREPEAT_EN when it is defined.
module tb_rs_pulse_driver;

  localparam int DEB   = 4;
  localparam int REP   = 8;
  localparam int CNT_W = 16;
`ifdef RS_PULSE_DRIVER_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  rs_pulse_driver_if bus();

  rs_pulse_driver #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int t;
  int s_cnt, s_first, s_last;
  int r_cnt, r_first, r_last;
  int c_cnt, c_first;
  int both_cnt, held_cnt;
  int exp_v;

  task automatic clear_obs();
    t        = 0;
    s_cnt    = 0; s_first = -1; s_last = -1;
    r_cnt    = 0; r_first = -1; r_last = -1;
    c_cnt    = 0; c_first = -1;
    both_cnt = 0;
    held_cnt = 0;
  endtask

  // Step one clock and log which outputs were high, indexed by cycles since clear_obs.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (bus.s === 1'b1) begin
      if (s_cnt == 0) s_first = t;
      s_last = t;
      s_cnt++;
    end
    if (bus.r === 1'b1) begin
      if (r_cnt == 0) r_first = t;
      r_last = t;
      r_cnt++;
    end
    if (bus.conflict === 1'b1) begin
      if (c_cnt == 0) c_first = t;
      c_cnt++;
    end
    if (bus.s === 1'b1 && bus.r === 1'b1) both_cnt++;
    if (bus.held === 1'b1) held_cnt++;
  endtask

  task automatic settle();
    bus.btn_s = 1'b0;
    bus.btn_r = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_s = 1'b1;
    bus.btn_r = 1'b1;
    clear_obs();
    repeat (4) tick();
    vectors++; if (s_cnt !== 0) begin miscompares++; $display("FAIL reset_s: got %0d high cycles, expected 0", s_cnt); end
    vectors++; if (r_cnt !== 0) begin miscompares++; $display("FAIL reset_r: got %0d high cycles, expected 0", r_cnt); end
    vectors++; if (c_cnt !== 0) begin miscompares++; $display("FAIL reset_conflict: got %0d high cycles, expected 0", c_cnt); end
    vectors++; if (held_cnt !== 0) begin miscompares++; $display("FAIL reset_held: got %0d high cycles, expected 0", held_cnt); end
    clear_obs();
    rst = 1'b0;
    bus.btn_r = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 12) bus.btn_s = 1'b0;
      tick();
    end
    vectors++; if (s_first !== 7) begin miscompares++; $display("FAIL reset_release_latency: got %0d, expected 7", s_first); end
    vectors++; if (s_cnt !== 1) begin miscompares++; $display("FAIL reset_release_count: got %0d, expected 1", s_cnt); end
    vectors++; if (c_cnt !== 0) begin miscompares++; $display("FAIL reset_release_conflict: got %0d, expected 0", c_cnt); end
    settle();
  endtask

  task automatic test_clean_press();
    clear_obs();
    bus.btn_s = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) bus.btn_s = 1'b0;
      tick();
      if (t == 7) begin
        vectors++; if (bus.held !== 1'b0) begin miscompares++; $display("FAIL press_held_before: got %b at t=7, expected 0", bus.held); end
      end
      if (t == 8) begin
        vectors++; if (bus.held !== 1'b1) begin miscompares++; $display("FAIL press_held_rise: got %b at t=8, expected 1", bus.held); end
      end
      if (t == 26) begin
        vectors++; if (bus.held !== 1'b1) begin miscompares++; $display("FAIL press_held_rel: got %b at t=26, expected 1", bus.held); end
      end
      if (t == 27) begin
        vectors++; if (bus.held !== 1'b0) begin miscompares++; $display("FAIL press_held_drop: got %b at t=27, expected 0", bus.held); end
      end
    end
    exp_v = AUTOREP ? 2 : 1;
    vectors++; if (s_cnt !== exp_v) begin miscompares++; $display("FAIL press_s_count: got %0d, expected %0d", s_cnt, exp_v); end
    vectors++; if (s_first !== 7) begin miscompares++; $display("FAIL press_s_latency: got %0d, expected 7", s_first); end
    vectors++; if (r_cnt !== 0) begin miscompares++; $display("FAIL press_r_count: got %0d, expected 0", r_cnt); end
    settle();
  endtask

  task automatic test_glitch();
    clear_obs();
    for (int i = 0; i < 15; i++) begin
      bus.btn_s = (i < 3) ? 1'b1 : 1'b0;
      tick();
    end
    vectors++; if (s_cnt !== 0) begin miscompares++; $display("FAIL glitch3_s_count: got %0d, expected 0", s_cnt); end
    vectors++; if (held_cnt !== 0) begin miscompares++; $display("FAIL glitch3_held: got %0d high cycles, expected 0", held_cnt); end
    clear_obs();
    for (int i = 0; i < 15; i++) begin
      bus.btn_s = (i < 4) ? 1'b1 : 1'b0;
      tick();
    end
    vectors++; if (s_cnt !== 1) begin miscompares++; $display("FAIL glitch4_s_count: got %0d, expected 1", s_cnt); end
    vectors++; if (s_first !== 7) begin miscompares++; $display("FAIL glitch4_s_latency: got %0d, expected 7", s_first); end
    settle();
  endtask

  task automatic test_bounce();
    logic [4:0] press_pat;
    logic [4:0] rel_pat;
    press_pat = 5'b01101;
    rel_pat   = 5'b01010;
    clear_obs();
    for (int i = 0; i < 45; i++) begin
      if (i < 5) bus.btn_s = press_pat[i];
      else if (i < 25) bus.btn_s = 1'b1;
      else if (i < 30) bus.btn_s = rel_pat[i-25];
      else bus.btn_s = 1'b0;
      tick();
    end
    exp_v = AUTOREP ? 2 : 1;
    vectors++; if (s_cnt !== exp_v) begin miscompares++; $display("FAIL bounce_s_count: got %0d, expected %0d", s_cnt, exp_v); end
    vectors++; if (s_first !== 12) begin miscompares++; $display("FAIL bounce_s_first: got %0d, expected 12", s_first); end
    exp_v = AUTOREP ? 21 : 12;
    vectors++; if (s_last !== exp_v) begin miscompares++; $display("FAIL bounce_s_last: got %0d, expected %0d", s_last, exp_v); end
    settle();
  endtask

  task automatic test_simultaneous();
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      bus.btn_s = (i < 20) ? 1'b1 : 1'b0;
      bus.btn_r = (i < 20) ? 1'b1 : 1'b0;
      tick();
    end
    exp_v = AUTOREP ? 2 : 1;
    vectors++; if (c_cnt !== exp_v) begin miscompares++; $display("FAIL simul_conflict_count: got %0d, expected %0d", c_cnt, exp_v); end
    vectors++; if (c_first !== 7) begin miscompares++; $display("FAIL simul_conflict_first: got %0d, expected 7", c_first); end
    vectors++; if (s_cnt !== 0) begin miscompares++; $display("FAIL simul_s_count: got %0d, expected 0", s_cnt); end
    vectors++; if (r_cnt !== 0) begin miscompares++; $display("FAIL simul_r_count: got %0d, expected 0", r_cnt); end
    settle();
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      bus.btn_s = (i < 20) ? 1'b1 : 1'b0;
      bus.btn_r = (i >= 2 && i < 22) ? 1'b1 : 1'b0;
      tick();
    end
    vectors++; if (s_first !== 7) begin miscompares++; $display("FAIL stagger_s_first: got %0d, expected 7", s_first); end
    vectors++; if (r_first !== 9) begin miscompares++; $display("FAIL stagger_r_first: got %0d, expected 9", r_first); end
    vectors++; if (c_cnt !== 0) begin miscompares++; $display("FAIL stagger_conflict: got %0d, expected 0", c_cnt); end
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL stagger_s_and_r: got %0d cycles, expected 0", both_cnt); end
    exp_v = AUTOREP ? 2 : 1;
    vectors++; if (r_cnt !== exp_v) begin miscompares++; $display("FAIL stagger_r_count: got %0d, expected %0d", r_cnt, exp_v); end
    settle();
  endtask

  task automatic test_midpress_reset();
    clear_obs();
    bus.btn_r = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    clear_obs();
    repeat (3) tick();
    vectors++; if (r_cnt !== 0) begin miscompares++; $display("FAIL midrst_r_in_reset: got %0d, expected 0", r_cnt); end
    vectors++; if (held_cnt !== 0) begin miscompares++; $display("FAIL midrst_held_in_reset: got %0d, expected 0", held_cnt); end
    rst = 1'b0;
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      if (i == 12) bus.btn_r = 1'b0;
      tick();
    end
    vectors++; if (r_first !== 7) begin miscompares++; $display("FAIL midrst_r_latency: got %0d, expected 7", r_first); end
    vectors++; if (r_cnt !== 1) begin miscompares++; $display("FAIL midrst_r_count: got %0d, expected 1", r_cnt); end
    settle();
  endtask

  task automatic test_autorepeat();
    clear_obs();
    for (int i = 0; i < 50; i++) begin
      bus.btn_r = (i < 38) ? 1'b1 : 1'b0;
      tick();
    end
    exp_v = AUTOREP ? 4 : 1;
    vectors++; if (r_cnt !== exp_v) begin miscompares++; $display("FAIL repeat_r_count: got %0d, expected %0d", r_cnt, exp_v); end
    vectors++; if (r_first !== 7) begin miscompares++; $display("FAIL repeat_r_first: got %0d, expected 7", r_first); end
    exp_v = AUTOREP ? 34 : 7;
    vectors++; if (r_last !== exp_v) begin miscompares++; $display("FAIL repeat_r_last: got %0d, expected %0d", r_last, exp_v); end
    vectors++; if (s_cnt !== 0) begin miscompares++; $display("FAIL repeat_s_count: got %0d, expected 0", s_cnt); end
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.btn_s = 1'b0;
    bus.btn_r = 1'b0;
    rst = 1'b1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_midpress_reset();
    test_autorepeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
